// File: rtl/vga_sync_pattern_gen.sv
// VGA timing decode and test-pattern generator: two-stage registered pipeline
// from the free-running position counts to sync, blanking, coordinates and RGB.
module vga_sync_pattern_gen #(
  parameter int   CW        = 10,
  parameter int   H_VISIBLE = 640,
  parameter int   H_FRONT   = 16,
  parameter int   H_SYNC    = 96,
  parameter int   H_BACK    = 48,
  parameter int   V_VISIBLE = 480,
  parameter int   V_FRONT   = 10,
  parameter int   V_SYNC    = 2,
  parameter int   V_BACK    = 33,
  parameter logic SYNC_POL  = 1'b0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [CW-1:0] horizontal,
  input  logic [CW-1:0] vertical,
  input  logic [1:0]    mode_sel,
  input  logic [11:0]   fill_color,
  output logic          hsync,
  output logic          vsync,
  output logic          video_on,
  output logic [CW-1:0] pixel_x,
  output logic [CW-1:0] pixel_y,
  output logic [11:0]   rgb,
  output logic          line_start,
  output logic          frame_start
);

  localparam logic [CW-1:0] H_VIS_C    = CW'(H_VISIBLE);
  localparam logic [CW-1:0] H_SYNC_BEG = CW'(H_VISIBLE + H_FRONT);
  localparam logic [CW-1:0] H_SYNC_END = CW'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [CW-1:0] H_TOTAL_C  = CW'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK);
  localparam logic [CW-1:0] V_VIS_C    = CW'(V_VISIBLE);
  localparam logic [CW-1:0] V_SYNC_BEG = CW'(V_VISIBLE + V_FRONT);
  localparam logic [CW-1:0] V_SYNC_END = CW'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [CW-1:0] V_TOTAL_C  = CW'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK);
  localparam int            BAR_W      = 80;

  // Bar index = x / 80, saturating at the last bar for wide visible areas.
  function automatic logic [2:0] bar_index(input logic [CW-1:0] x);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 1; i < 8; i++) begin
      idx = (int'(x) >= i * BAR_W) ? 3'(i) : idx;
    end
    return idx;
  endfunction

  function automatic logic [11:0] bar_color(input logic [2:0] idx);
    logic [11:0] c;
    case (idx)
      3'd0:    c = 12'hFFF;
      3'd1:    c = 12'hFF0;
      3'd2:    c = 12'h0FF;
      3'd3:    c = 12'h0F0;
      3'd4:    c = 12'hF0F;
      3'd5:    c = 12'hF00;
      3'd6:    c = 12'h00F;
      default: c = 12'h000;
    endcase
    return c;
  endfunction

  logic          in_range_s, h_act_s, v_act_s, vis_s, line_s, frame_s;
  logic          hs1_r, vs1_r, vid1_r, ls1_r, fs1_r;
  logic [CW-1:0] px1_r, py1_r;
  logic [1:0]    active_mode_r;
  logic [7:0]    frame_cnt_r;
  logic [11:0]   rgb_next_s;

  // Stage-1 decode; counts beyond the frame are treated as plain blanking.
  always_comb begin
    in_range_s = (horizontal < H_TOTAL_C) && (vertical < V_TOTAL_C);
    h_act_s    = in_range_s && (horizontal >= H_SYNC_BEG) && (horizontal < H_SYNC_END);
    v_act_s    = in_range_s && (vertical >= V_SYNC_BEG) && (vertical < V_SYNC_END);
    vis_s      = (horizontal < H_VIS_C) && (vertical < V_VIS_C);
    line_s     = in_range_s && (horizontal == {CW{1'b0}});
    frame_s    = line_s && (vertical == {CW{1'b0}});
  end

  // Stage-1 registers; pattern mode and frame counter only move at frame start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs1_r         <= ~SYNC_POL;
      vs1_r         <= ~SYNC_POL;
      vid1_r        <= 1'b0;
      px1_r         <= {CW{1'b0}};
      py1_r         <= {CW{1'b0}};
      ls1_r         <= 1'b0;
      fs1_r         <= 1'b0;
      active_mode_r <= 2'd0;
      frame_cnt_r   <= 8'd0;
    end else begin
      hs1_r  <= h_act_s ? SYNC_POL : ~SYNC_POL;
      vs1_r  <= v_act_s ? SYNC_POL : ~SYNC_POL;
      vid1_r <= vis_s;
      px1_r  <= vis_s ? horizontal : {CW{1'b0}};
      py1_r  <= vis_s ? vertical : {CW{1'b0}};
      ls1_r  <= line_s;
      fs1_r  <= frame_s;
      if (frame_s) begin
        active_mode_r <= mode_sel;
        frame_cnt_r   <= frame_cnt_r + 8'd1;
      end else begin
        active_mode_r <= active_mode_r;
        frame_cnt_r   <= frame_cnt_r;
      end
    end
  end

  // Stage-2 pattern selection; blanked pixels are always black.
  always_comb begin
    rgb_next_s = 12'h000;
    if (vid1_r) begin
      case (active_mode_r)
        2'd0:    rgb_next_s = bar_color(bar_index(px1_r));
        2'd1:    rgb_next_s = (px1_r[5] ^ py1_r[5]) ? 12'h000 : 12'hFFF;
        2'd2:    rgb_next_s = {px1_r[7:4], py1_r[7:4], frame_cnt_r[3:0]};
        2'd3:    rgb_next_s = fill_color;
        default: rgb_next_s = 12'h000;
      endcase
    end else begin
      rgb_next_s = 12'h000;
    end
  end

  // Stage-2 output registers keep every output aligned to the same sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      video_on    <= 1'b0;
      pixel_x     <= {CW{1'b0}};
      pixel_y     <= {CW{1'b0}};
      rgb         <= 12'h000;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hsync       <= hs1_r;
      vsync       <= vs1_r;
      video_on    <= vid1_r;
      pixel_x     <= px1_r;
      pixel_y     <= py1_r;
      rgb         <= rgb_next_s;
      line_start  <= ls1_r;
      frame_start <= fs1_r;
    end
  end

endmodule

// File: tb/tb_vga_sync_pattern_gen.sv
// Scoreboard bench: driver pushes modelled expectations, monitor pops and
// compares one DUT output sample per clock.
module tb_vga_sync_pattern_gen;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  horizontal = 10'd0;
  logic [9:0]  vertical = 10'd0;
  logic [1:0]  mode_sel = 2'd0;
  logic [11:0] fill_color = 12'h000;
  logic        hsync, vsync, video_on, line_start, frame_start;
  logic [9:0]  pixel_x, pixel_y;
  logic [11:0] rgb;

  vga_sync_pattern_gen dut (
    .clk(clk), .reset(reset), .horizontal(horizontal), .vertical(vertical),
    .mode_sel(mode_sel), .fill_color(fill_color), .hsync(hsync), .vsync(vsync),
    .video_on(video_on), .pixel_x(pixel_x), .pixel_y(pixel_y), .rgb(rgb),
    .line_start(line_start), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        hs, vs, vid, ls, fs, use_fill;
    logic [9:0]  px, py;
    logic [11:0] rgb;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          m_mode = 0;
  int          m_fcnt = 0;
  int          ls_cnt = 0;
  int          fs_cnt = 0;
  logic [11:0] bars [0:7] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                              12'hF0F, 12'hF00, 12'h00F, 12'h000};

  // Reference model: 800x525 frame, 640x480 visible, active-low syncs.
  function automatic exp_t model(input int h, input int v, input int msel);
    exp_t e;
    bit   in_range, vis;
    int   bar;
    in_range = (h < 800) && (v < 525);
    vis      = (h < 640) && (v < 480);
    if (in_range && h == 0 && v == 0) begin
      m_mode = msel;
      m_fcnt = (m_fcnt + 1) % 256;
    end
    e.hs  = !(in_range && h >= 656 && h < 752);
    e.vs  = !(in_range && v >= 490 && v < 492);
    e.vid = vis;
    e.px  = vis ? 10'(h) : 10'd0;
    e.py  = vis ? 10'(v) : 10'd0;
    e.ls  = in_range && (h == 0);
    e.fs  = in_range && (h == 0) && (v == 0);
    e.use_fill = 1'b0;
    e.rgb = 12'h000;
    if (vis) begin
      case (m_mode)
        0: begin
          bar = h / 80;
          if (bar > 7) bar = 7;
          e.rgb = bars[bar];
        end
        1: e.rgb = (((h / 32) % 2) == ((v / 32) % 2)) ? 12'hFFF : 12'h000;
        2: e.rgb = 12'(((h / 16) % 16) * 256 + ((v / 16) % 16) * 16 + (m_fcnt % 16));
        default: e.use_fill = 1'b1;
      endcase
    end
    return e;
  endfunction

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic chk_reset(input string tag);
    check({tag, ".hsync"}, hsync, 1);
    check({tag, ".vsync"}, vsync, 1);
    check({tag, ".video_on"}, video_on, 0);
    check({tag, ".pixel_x"}, pixel_x, 0);
    check({tag, ".pixel_y"}, pixel_y, 0);
    check({tag, ".rgb"}, rgb, 0);
    check({tag, ".line_start"}, line_start, 0);
    check({tag, ".frame_start"}, frame_start, 0);
  endtask

  // Monitor: one output sample per clock, compared against the oldest expectation.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (reset) begin
      chk_reset("in_reset");
    end else begin
      if (line_start) ls_cnt++;
      if (frame_start) fs_cnt++;
      if (q.size() >= 2) begin
        e = q.pop_front();
        if (e.use_fill) e.rgb = fill_color;
        check("hsync", hsync, e.hs);
        check("vsync", vsync, e.vs);
        check("video_on", video_on, e.vid);
        check("pixel_x", pixel_x, e.px);
        check("pixel_y", pixel_y, e.py);
        check("rgb", rgb, e.rgb);
        check("line_start", line_start, e.ls);
        check("frame_start", frame_start, e.fs);
      end
    end
  end

  task automatic push_cur();
    q.push_back(model(int'(horizontal), int'(vertical), int'(mode_sel)));
  endtask

  task automatic drive(input int h, input int v, input int m, input int f);
    @(negedge clk);
    horizontal = 10'(h);
    vertical   = 10'(v);
    mode_sel   = 2'(m);
    fill_color = 12'(f);
    if (!reset) push_cur();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(900, 900, int'(mode_sel), int'(fill_color));
  endtask

  task automatic assert_reset();
    exp_t r;
    #2;
    reset = 1'b1;
    q.delete();
    m_mode = 0;
    m_fcnt = 0;
    #1;
    chk_reset("async_reset");
  endtask

  task automatic rel_reset();
    exp_t r;
    @(negedge clk);
    reset = 1'b0;
    r.hs = 1'b1; r.vs = 1'b1; r.vid = 1'b0; r.ls = 1'b0; r.fs = 1'b0;
    r.use_fill = 1'b0; r.px = 10'd0; r.py = 10'd0; r.rgb = 12'h000;
    q.push_back(r);
    push_cur();
  endtask

  int hlist [18] = '{0, 1, 2, 79, 80, 81, 159, 160, 639, 640, 641,
                     655, 656, 657, 751, 752, 753, 799};

  initial begin
    int ls0, fs0, h, v;
    // Reset held with a visible count, then release.
    repeat (3) drive(100, 100, 0, 0);
    rel_reset();
    repeat (3) drive(100, 100, 0, 0);

    // Compressed full frame: every line, key columns; two lines in full.
    idle(4);
    ls0 = ls_cnt;
    fs0 = fs_cnt;
    for (int vv = 0; vv < 525; vv++) begin
      if (vv == 0 || vv == 490) begin
        for (int hh = 0; hh < 800; hh++) drive(hh, vv, 0, 0);
      end else begin
        for (int k = 0; k < 18; k++) drive(hlist[k], vv, 0, 0);
      end
    end
    idle(4);
    check("line_start_count", ls_cnt - ls0, 525);
    check("frame_start_count", fs_cnt - fs0, 1);

    // Colour bars at the bar/visible boundary.
    drive(0, 0, 0, 0);
    drive(80, 10, 0, 0);
    drive(639, 10, 0, 0);
    drive(640, 10, 0, 0);
    // Checkerboard.
    drive(0, 0, 1, 0);
    drive(31, 0, 1, 0);
    drive(32, 0, 1, 0);
    drive(32, 32, 1, 0);
    // Mid-frame switch to solid: bars persist until next frame start.
    drive(0, 0, 0, 12'hA5C);
    drive(100, 200, 3, 12'hA5C);
    drive(300, 479, 3, 12'hA5C);
    drive(0, 0, 3, 12'hA5C);
    drive(5, 5, 3, 12'h123);
    drive(6, 5, 3, 12'h456);
    // Gradient over 17 frames: blue nibble steps and wraps.
    for (int f = 0; f < 17; f++) begin
      drive(0, 0, 2, 0);
      drive(200, 100, 2, 0);
      drive(639, 479, 2, 0);
      drive(1000, 600, 2, 0);
    end

    // Randomized counts, modes and colours with occasional frame starts.
    for (int i = 0; i < 3000; i++) begin
      h = int'($urandom_range(0, 1023));
      v = int'($urandom_range(0, 1023));
      if ($urandom_range(0, 3) == 0) v = int'($urandom_range(0, 524));
      if ($urandom_range(0, 3) == 0) h = int'($urandom_range(0, 799));
      if ($urandom_range(0, 40) == 0) begin h = 0; v = 0; end
      drive(h, v, int'($urandom_range(0, 3)), int'($urandom_range(0, 4095)));
    end

    // Reset asserted mid-line, then resume with new counts.
    drive(0, 0, 2, 0);
    drive(300, 100, 2, 0);
    drive(301, 100, 2, 0);
    assert_reset();
    repeat (3) drive(302, 100, 1, 0);
    rel_reset();
    for (int i = 0; i < 400; i++) begin
      drive(int'($urandom_range(0, 850)), int'($urandom_range(0, 530)),
            int'($urandom_range(0, 3)), int'($urandom_range(0, 4095)));
    end
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not complete, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

endmodule
